// File: rtl/dmem_responder.sv
// Single-port 64x32 data memory responder with a fixed-latency FSM; range checking under DMEM_RANGE_CHECK_EN.
// Latency: response valid LATENCY+1 cycles after acceptance (counting the cycle right after the acceptance edge as 1).
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
module dmem_responder #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_alive;
    logic        r_we;
    logic [5:0]  r_idx;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [0:63];

    logic        w_accept;
    logic        w_err;
    logic        w_load_rsp;
    logic        w_rsp_we;
    logic [5:0]  w_rsp_idx;
    logic        w_rsp_err;
    logic [31:0] w_rsp_data;

`ifdef DMEM_RANGE_CHECK_EN
    assign w_err = (req_addr[31:8] != 24'd0) || (req_addr[1:0] != 2'd0);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{req_addr[31:8], req_addr[1:0]};
    assign w_err = 1'b0;
`endif

    // r_alive holds req_ready low until the first edge after reset release
    assign req_ready = (r_state == IDLE) && r_alive;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_rsp_err;

    // With zero latency the response is captured on the acceptance edge, straight from the request
    assign w_rsp_we   = (r_state == IDLE) ? req_we         : r_we;
    assign w_rsp_idx  = (r_state == IDLE) ? req_addr[7:2]  : r_idx;
    assign w_rsp_err  = (r_state == IDLE) ? w_err          : r_err;
    assign w_rsp_data = (!w_rsp_we && !w_rsp_err) ? r_mem[w_rsp_idx] : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_rsp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LAT == 3'd0) begin
                        w_state_nxt = RESP;
                        w_load_rsp  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LAT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = RESP;
                    w_load_rsp  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_alive   <= 1'b0;
            r_we      <= 1'b0;
            r_idx     <= 6'd0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_alive <= 1'b1;
            if (w_accept) begin
                r_we  <= req_we;
                r_idx <= req_addr[7:2];
                r_err <= w_err;
            end
            if (w_load_rsp) begin
                r_rdata   <= w_rsp_data;
                r_rsp_err <= w_rsp_err;
            end
        end
    end

    // Storage is never reset, so an accepted store survives a later reset
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr[7:2]][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=2 and one LATENCY=0 instance, scoreboard of expected responses.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Both instances share request fields; sel0 steers valid/ready to one of them.
`timescale 1ns/1ps
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel0;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        rv2, rr2, sv2, se2, rspr2;
    logic [31:0] sd2;
    logic        rv0, rr0, sv0, se0, rspr0;
    logic [31:0] sd0;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    rsp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    assign rv2   = req_valid && !sel0;
    assign rv0   = req_valid && sel0;
    assign rspr2 = rsp_ready && !sel0;
    assign rspr0 = rsp_ready && sel0;

    assign m_req_ready = sel0 ? rr0 : rr2;
    assign m_rsp_valid = sel0 ? sv0 : sv2;
    assign m_rsp_rdata = sel0 ? sd0 : sd2;
    assign m_rsp_err   = sel0 ? se0 : se2;

    dmem_responder #(.LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(rv2), .req_ready(rr2), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(sv2), .rsp_ready(rspr2), .rsp_rdata(sd2), .rsp_err(se2)
    );

    dmem_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv0), .req_ready(rr0), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(sv0), .rsp_ready(rspr0), .rsp_rdata(sd0), .rsp_err(se0)
    );

    task automatic run_txn(input logic use0, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int          n;
        int          exp_lat;
        rsp_t        exp;
        logic [31:0] first;
        sel0      = use0;
        exp_lat   = use0 ? 0 : 2;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        n = 0;
        while (m_req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_total++;
        if (m_req_ready !== 1'b1) begin
            $display("FAIL accept_timeout addr=%h: req_ready=%b, required 1", addr, m_req_ready);
            req_valid = 1'b0;
            return;
        end else n_pass++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        n = 0;
        while (m_rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_total++;
        if (n !== exp_lat) begin
            $display("FAIL rsp_latency addr=%h: rsp_valid after %0d cycles, required %0d", addr, n + 1, exp_lat + 1);
            if (m_rsp_valid !== 1'b1) begin
                void'(sb.pop_front());
                return;
            end
        end else n_pass++;
        first = m_rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== first || m_req_ready !== 1'b0)
                $display("FAIL rsp_hold cycle %0d: valid=%b rdata=%h req_ready=%b, required 1 %h 0",
                         i, m_rsp_valid, m_rsp_rdata, m_req_ready, first);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        exp = sb.pop_front();
        n_total++;
        if (m_rsp_rdata !== exp.rdata || m_rsp_err !== exp.err || m_req_ready !== 1'b0)
            $display("FAIL rsp_data addr=%h: rdata=%h err=%b req_ready=%b, required %h %b 0",
                     addr, m_rsp_rdata, m_rsp_err, m_req_ready, exp.rdata, exp.err);
        else n_pass++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_total++;
        if (m_rsp_valid !== 1'b0 || m_req_ready !== 1'b1)
            $display("FAIL post_handshake addr=%h: rsp_valid=%b req_ready=%b, required 0 1",
                     addr, m_rsp_valid, m_req_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel0 = (s == 1);
            #1;
            n_total++;
            if (m_req_ready !== 1'b0 || m_rsp_valid !== 1'b0 || m_rsp_rdata !== 32'd0 || m_rsp_err !== 1'b0)
                $display("FAIL reset_state dut%0d: rr=%b rv=%b rd=%h re=%b, required 0 0 0 0",
                         s, m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err);
            else n_pass++;
        end
        sel0  = 1'b0;
        reset = 1'b1;
        #1;
        n_total++;
        if (m_req_ready !== 1'b0)
            $display("FAIL ready_before_edge: req_ready=%b, required 0", m_req_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (rr2 !== 1'b1 || rr0 !== 1'b1)
            $display("FAIL ready_after_edge: rr2=%b rr0=%b, required 1 1", rr2, rr0);
        else n_pass++;
    endtask

    task automatic test_store_load();
        run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 2);
    endtask

    task automatic test_byte_enable();
        run_txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'd0, 1'b0, 0);
        run_txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB33DD, 1'b0, 0);
        run_txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    endtask

    task automatic test_latency0();
        run_txn(1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0, 0);
        run_txn(1'b1, 1'b0, 32'h04, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, 5);
    endtask

    task automatic test_range();
        run_txn(1'b0, 1'b1, 32'h00, 32'h01020304, 4'hF, 32'd0, 1'b0, 0);
`ifdef DMEM_RANGE_CHECK_EN
        run_txn(1'b0, 1'b1, 32'h100, 32'h55AA55AA, 4'hF, 32'd0, 1'b1, 0);
        run_txn(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, 32'h01020304, 1'b0, 0);
`else
        run_txn(1'b0, 1'b1, 32'h100, 32'h55AA55AA, 4'hF, 32'd0, 1'b0, 0);
        run_txn(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, 32'h55AA55AA, 1'b0, 0);
`endif
    endtask

    task automatic test_reset_mid();
        logic seen;
        sel0      = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_total++;
        if (m_rsp_valid !== 1'b0 || m_req_ready !== 1'b0)
            $display("FAIL mid_reset_hold: rsp_valid=%b req_ready=%b, required 0 0", m_rsp_valid, m_req_ready);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_total++;
        if (m_req_ready !== 1'b0)
            $display("FAIL mid_reset_release: req_ready=%b, required 0", m_req_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_req_ready !== 1'b1)
            $display("FAIL mid_reset_ready: req_ready=%b, required 1", m_req_ready);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (m_rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++;
        if (seen !== 1'b0)
            $display("FAIL aborted_rsp: rsp_valid rose=%b, required 0", seen);
        else n_pass++;
        run_txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 1);
    endtask

    initial begin
        reset     = 1'b0;
        sel0      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_latency0();
        test_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter: LATENCY, 2, wait cycles between request acceptance and response (legal 0..7).
REQ-002 The block SHALL have ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr[7:2].
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i writes byte i.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  CPU accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errored accesses.
- rsp_err  output  1  access error flag, valid with rsp_valid.

Function
REQ-003 Storage SHALL be 64 x 32-bit words; contents are not reset.
REQ-004 FSM states SHALL be IDLE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-006 On acceptance, req_we, req_addr[7:2], req_wdata, req_be and the error decision SHALL be latched.
REQ-007 A non-errored store SHALL write enabled bytes on the acceptance edge; disabled bytes are unchanged; req_be = 0 writes nothing and is not an error.
REQ-008 On acceptance, the FSM SHALL go to WAIT with a 3-bit counter loaded to LATENCY, or directly to RESP when LATENCY = 0.
REQ-009 In WAIT the counter SHALL decrement each cycle; the FSM moves to RESP on the edge where the counter equals 1.
REQ-010 rsp_valid SHALL first be 1 exactly LATENCY+1 cycles after the acceptance edge.
REQ-011 On entry to RESP, rsp_rdata SHALL be the latched word (load, no error) or 0 (store or error); rsp_rdata and rsp_err SHALL be registered and stable while rsp_valid = 1.
REQ-012 In RESP, rsp_valid SHALL stay 1 until rsp_ready = 1; on that edge the FSM returns to IDLE.
REQ-013 req_ready SHALL be 0 in the cycle in which the response is accepted, so the back-to-back period is LATENCY+2 cycles.
REQ-014 req_valid SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-015 A load issued after a store to the same word SHALL return the stored data.
REQ-016 Stores SHALL also receive a response (rsp_rdata = 0).

Reset
REQ-017 While reset = 0, the FSM SHALL be IDLE, the counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and req_ready 0; req_ready rises to 1 on the first clock edge after reset deasserts.
REQ-018 A reset asserted mid-transaction SHALL abort it with no response; a store already accepted remains written.

Configuration
REQ-019 With DMEM_RANGE_CHECK_EN defined, an access with req_addr[31:8] != 0 or req_addr[1:0] != 0 SHALL be errored: the store is suppressed, rsp_rdata = 0, rsp_err = 1.
REQ-020 Without DMEM_RANGE_CHECK_EN, the address bits outside [7:2] SHALL be ignored and rsp_err SHALL be tied to 0.

Verification
REQ-021 LATENCY=2: store 0xDEADBEEF at 0x10 with be=4'hF, then load 0x10 -> rsp_valid 3 cycles after each acceptance, load rdata = 0xDEADBEEF, err = 0.
REQ-022 Word at 0x20 = 0x11223344; store 0xAABBCCDD with be=4'b0101, then load -> rdata = 0x11BB33DD.
REQ-023 LATENCY=0: load 0x04 with rsp_ready held 0 for 5 cycles -> rsp_valid is 1 from cycle 1 after acceptance, rdata is stable, req_ready = 0 until one cycle after the handshake.
REQ-024 With DMEM_RANGE_CHECK_EN: store to 0x100, then load 0x00 -> store response err = 1; word 0 is unchanged. Without the macro: the same store writes word 0 and err = 0.
REQ-025 Assert reset for 1 cycle during WAIT of a load -> rsp_valid never rises for that load; req_ready = 1 one edge after release; a new load completes normally.
